// File: rtl/irq_pending_4_v.sv
// irq_pending_4_v: latches four request lines into a pending register and offers the highest-priority
// eligible line as a handshaked 2-bit code. Optional macro: IRQ_PEND_EDGE_EN (edge capture + overflow flags).
`default_nettype none

module irq_pending_4_v #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_req,
  input  logic [3:0]       i_mask,
  input  logic             i_ready,
  output logic [1:0]       o_code,
  output logic             o_valid,
  output logic [3:0]       o_pending,
  output logic [3:0]       o_overflow,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [3:0]       pending;
  logic [3:0]       overflow;
  logic [3:0]       capture;
  logic [3:0]       eligible;
  logic [3:0]       clr_vec;
  logic [1:0]       code;
  logic [1:0]       code_sel;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             load;

`ifdef IRQ_PEND_EDGE_EN
  logic [3:0] prev_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_req <= 4'b0000;
    end else begin
      prev_req <= i_req;
    end
  end

  assign capture = i_req & ~prev_req;

  // A capture that lands on a bit being cleared this cycle is absorbed by set-wins, not lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow <= 4'b0000;
    end else begin
      overflow <= overflow | (capture & pending & ~clr_vec);
    end
  end
`else
  assign capture  = i_req;
  assign overflow = 4'b0000;
`endif

  assign eligible = pending & ~i_mask;

  always_comb begin
    code_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) begin
        code_sel = 2'(i);
      end
    end
  end

  generate
    for (genvar n = 0; n < 4; n++) begin : g_clr
      assign clr_vec[n] = accept && (code == 2'(n));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|eligible) state_nxt = S_OFFER;
      S_OFFER: if (i_ready)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    accept = 1'b0;
    case (state)
      S_IDLE:  load   = |eligible;
      S_OFFER: accept = i_ready;
      default: ;
    endcase
  end

  // The code is only loaded from IDLE, which freezes it for the whole offer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      code    <= 2'd0;
      count   <= '0;
      pending <= 4'b0000;
    end else begin
      if (load) begin
        code <= code_sel;
      end
      if (accept) begin
        count <= count + 1'b1;
      end
      pending <= (pending & ~clr_vec) | capture;
    end
  end

  assign o_code     = code;
  assign o_valid    = (state == S_OFFER);
  assign o_pending  = pending;
  assign o_overflow = overflow;
  assign o_count    = count;

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_4_v.sv
// Scoreboard bench for irq_pending_4_v: expected grant codes are queued by the stimulus, the monitor pops on accept.
`default_nettype none

module tb_irq_pending_4_v;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    mask;
  logic          ready;
  logic [1:0]    code;
  logic          valid;
  logic [3:0]    pending;
  logic [3:0]    overflow;
  logic [CW-1:0] count;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_count = 0;
  logic [1:0] exp_q[$];

`ifdef IRQ_PEND_EDGE_EN
  localparam logic [3:0] OVF3 = 4'b1000;
`else
  localparam logic [3:0] OVF3 = 4'b0000;
`endif

  irq_pending_4_v #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_mask(mask), .i_ready(ready),
    .o_code(code), .o_valid(valid), .o_pending(pending), .o_overflow(overflow), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an accept happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", int'(code), -1);
      end else begin
        chk("grant_code", int'(code), int'(exp_q.pop_front()));
      end
      exp_count = (exp_count + 1) % (1 << CW);
    end
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((pending != 4'b0000 || valid || exp_q.size() != 0) && k < 40) begin
      tick();
      k++;
    end
    chk({name, "_drain_timeout"}, k, (k < 40) ? k : 0);
    chk({name, "_count"}, int'(count), exp_count);
  endtask

  task automatic pulse(input logic [3:0] r);
    req = r;
    tick();
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; mask = 4'b0000; ready = 1'b0;

    // Reset with all lines held high, then release.
    tick(); tick();
    chk("rst_valid", int'(valid), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b0;
    tick();
    req = 4'b0000;
    chk("rel_pending", int'(pending), 4'b1111);
    chk("rel_valid0", int'(valid), 0);
    tick();
    chk("rel_valid1", int'(valid), 1);
    chk("rel_code", int'(code), 0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    ready = 1'b1;
    drain("all4");

    // Priority order, one grant per two cycles.
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    pulse(4'b1010);
    chk("prio_pend", int'(pending), 4'b1010);
    tick();
    chk("prio_v1", int'(valid), 1);
    chk("prio_c1", int'(code), 1);
    tick();
    chk("prio_gap", int'(valid), 0);
    chk("prio_pend2", int'(pending), 4'b1000);
    tick();
    chk("prio_v2", int'(valid), 1);
    chk("prio_c2", int'(code), 3);
    drain("prio");
    chk("prio_pend_end", int'(pending), 0);

    // Frozen offer: a higher-priority arrival does not displace line 2.
    ready = 1'b0;
    pulse(4'b0100);
    tick();
    chk("frz_code_a", int'(code), 2);
    pulse(4'b0001);
    tick(); tick();
    chk("frz_valid", int'(valid), 1);
    chk("frz_code_b", int'(code), 2);
    chk("frz_pend", int'(pending), 4'b0101);
    exp_q.push_back(2'd2); exp_q.push_back(2'd0);
    ready = 1'b1;
    drain("frz");

    // Mask: line 0 latches but is not offered until unmasked.
    mask = 4'b0001;
    exp_q.push_back(2'd1);
    pulse(4'b0011);
    repeat (4) tick();
    chk("mask_pend", int'(pending), 4'b0001);
    chk("mask_valid", int'(valid), 0);
    chk("mask_q", exp_q.size(), 0);
    exp_q.push_back(2'd0);
    mask = 4'b0000;
    drain("mask");

    // Request coinciding with its own accept: set wins, no overflow.
    ready = 1'b0;
    pulse(4'b0100);
    tick();
    chk("coin_code", int'(code), 2);
    exp_q.push_back(2'd2);
    ready = 1'b1; req = 4'b0100;
    tick();
    req = 4'b0000; ready = 1'b0;
    chk("coin_pend", int'(pending), 4'b0100);
    chk("coin_valid", int'(valid), 0);
    chk("coin_ovf", int'(overflow), 0);
    exp_q.push_back(2'd2);
    ready = 1'b1;
    drain("coin");

    // Overflow on line 3: second pulse hits a pending, un-accepted bit.
    ready = 1'b0;
    pulse(4'b1000);
    tick();
    pulse(4'b1000);
    tick();
    chk("ovf_set", int'(overflow), OVF3);
    chk("ovf_code", int'(code), 3);
    exp_q.push_back(2'd3);
    ready = 1'b1;
    drain("ovf");
    chk("ovf_sticky", int'(overflow), OVF3);

    // Reset during an offer drops it without counting.
    ready = 1'b0;
    pulse(4'b0010);
    tick();
    chk("rmid_valid_pre", int'(valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    chk("rmid_valid", int'(valid), 0);
    chk("rmid_count", int'(count), 0);
    chk("rmid_pend", int'(pending), 0);
    chk("rmid_ovf", int'(overflow), 0);

    // Count wrap: five accepts with a 2-bit counter ends at 1.
    ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    pulse(4'b1111);
    drain("wrap_a");
    exp_q.push_back(2'd0);
    pulse(4'b0001);
    drain("wrap_b");
    chk("wrap_final", int'(count), 1);
    chk("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_pending_4_v.md
# irq_pending_4_v

- Latches four request lines into a pending register.
- Presents the highest-priority eligible pending line (line 0 highest) as a 2-bit code with a valid/ready handshake, then clears that line once the consumer accepts it.
- Sits directly upstream of the 4-to-2 priority encoder stage. It turns raw, transient request lines into a stable, held request vector plus a registered, handshaked code.
- Used wherever single-cycle request pulses must not be lost while the consumer is busy.

## Interface

Parameters:
- CNT_W, default 8: width of the accepted-grant counter o_count.

Ports:
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_req  input  4  raw request lines; bit 0 has highest priority.
- i_mask  input  4  1 = line not offered; the line still latches into pending.
- i_ready  input  1  consumer accepts the current offer when i_ready and o_valid are high at a clock edge.
- o_code  output  2  index of the offered line; held stable while o_valid is high.
- o_valid  output  1  offer present.
- o_pending  output  4  pending register, direct register output.
- o_overflow  output  4  sticky per-line flag: a request was lost because the line was already pending.
- o_count  output  CNT_W  number of accepted grants; wraps modulo 2^CNT_W.

## Operation

Capture event, per line:
- With IRQ_PEND_EDGE_EN defined: i_req[n] is 1 and prev_req[n] is 0.
- Without it: i_req[n] is 1.

Pending register:
- Bit n is set on a capture event.
- Bit n is cleared on accept when o_code equals n.
- If set and clear hit the same bit in the same cycle, set wins: the bit stays 1 and no overflow is recorded.

Overflow:
- o_overflow[n] is set when a capture event hits an already-pending bit n that is not being cleared that cycle.
- Once set, it stays set until reset.
- In level mode (macro undefined), o_overflow is tied to 0.

Eligible set: o_pending & ~i_mask.

FSM with two states:
- IDLE, o_valid = 0:
  - If the eligible set is nonzero, load o_code with the lowest set index, set o_valid = 1, and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER, o_valid = 1:
  - o_code is frozen. New higher-priority pendings and changes to i_mask do not affect the current offer.
  - On accept: clear pending[o_code], increment o_count, set o_valid = 0, and go to IDLE.
  - Without accept: hold.

Behaviour at the boundaries:
- If the offered line becomes masked during OFFER, the offer still stands.
- o_count wraps from 2^CNT_W-1 to 0 with no flag.
- All four lines pending: lines are served 0, 1, 2, 3 in that order, as long as no new requests arrive.

## Timing

Reset (i_rst high at an edge), applied after that edge:
- o_valid = 0, o_code = 0, o_pending = 0, o_overflow = 0, o_count = 0.
- State returns to IDLE and prev_req = 0.
- Reset in the middle of an OFFER drops the offer; no count is recorded.
- Because prev_req resets to 0, a line held high when reset releases produces a capture on the first edge after release.

Cycle-level behaviour:
- Capture latency: capture at edge k gives o_pending set after edge k, and o_valid = 1 after edge k+1, when the FSM was in IDLE. That is 2 cycles from request to offer.
- Accept at edge m gives o_valid = 0, the pending bit cleared and o_count incremented, all after edge m.
- The earliest next offer is after edge m+1, so the peak rate is one grant per 2 cycles.
- i_ready has no effect while o_valid = 0.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration

IRQ_PEND_EDGE_EN:
- Defined: edge capture using the prev_req register, and overflow detection is active.
- Undefined: level capture. prev_req is not built and o_overflow is constant 0.
- In level mode, a line held high re-pends on the same cycle it is cleared (set wins).

## Test plan

- Reset check: hold i_rst for 2 cycles with i_req = 4'b1111, release, keep i_ready = 0:
  - o_pending = 4'b1111 after the first edge.
  - o_valid = 1 and o_code = 2'b00 one edge later.
- Priority order: pulse i_req = 4'b1010 for one cycle, keep i_ready = 1:
  - First grant is o_code = 01, second is o_code = 11, 2 cycles apart.
  - o_count = 2 and o_pending = 0 afterwards.
- Frozen offer: offer line 2 with i_ready = 0, then pulse i_req[0]:
  - o_code stays 10 until accept.
  - The next offer is 00.
- Mask: i_mask = 4'b0001, pulse i_req = 4'b0011:
  - Only 01 is offered, and o_pending[0] stays 1.
  - Clear the mask: 00 is offered.
- Overflow, edge mode: pulse i_req[3] twice while the line is pending and not accepted:
  - o_overflow = 4'b1000 and stays set through later accepts.
  - A pulse that coincides with the accept gives no overflow and o_pending[3] = 1.
- Count wrap, with CNT_W = 2: complete 5 accepts:
  - o_count ends at 1.
